fetch_execute_sequencer: RTL and testbench

Multi-cycle control sequencer for the 16-bit accumulator machine. It fetches instructions from main memory, decodes them and executes them. It owns the architectural registers (PC, AC, IR, MBR) and the operand address, and sits directly upstream of the ALU and main memory. It drives their address, data, write-enable and opcode inputs, and consumes their outputs. Instruction format: opcode = bits [15:12], address/operand = bits [11:0].

---
 rtl/fetch_execute_sequencer.sv | 148 ++++++++++++++
 tb/tb_fetch_execute_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_execute_sequencer.sv
// fetch_execute_sequencer
//   Multi-cycle control sequencer for the 16-bit accumulator machine. It
//   fetches, decodes and executes one instruction at a time. It owns PC, AC,
//   IR and MBR, and it drives main memory and the ALU.
//   Instruction format: opcode = ir[15:12], address/operand = ir[11:0].
//
// Ports
//   i_clk, i_reset      clock; asynchronous active-high reset
//   i_start             pulse; leaves IDLE and starts fetching at PC
//   o_mem_addr/wdata/we memory address {4'b0, addr12}, write data (= AC), write enable
//   i_mem_rdata         read data, valid the cycle after the address
//   o_alu_opcode/a/b    ALU select and operands (a = AC, b = MBR)
//   i_alu_result        combinational ALU result
//   o_pc, o_ac, o_ir    architectural registers
//   o_halted            high from entering HALT until reset
//   o_illegal_op        one-cycle pulse after decoding an opcode in 0xB..0xF
module fetch_execute_sequencer #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  output logic [15:0] o_mem_addr,
  output logic [15:0] o_mem_wdata,
  output logic        o_mem_we,
  input  logic [15:0] i_mem_rdata,
  output logic [3:0]  o_alu_opcode,
  output logic [15:0] o_alu_a,
  output logic [15:0] o_alu_b,
  input  logic [15:0] i_alu_result,
  output logic [11:0] o_pc,
  output logic [15:0] o_ac,
  output logic [15:0] o_ir,
  output logic        o_halted,
  output logic        o_illegal_op
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH_A, S_FETCH_D, S_DECODE, S_OPER_A,
    S_OPER_D, S_EXEC, S_STORE, S_HALT
  } state_t;

  state_t      r_state;
  logic [11:0] r_pc;
  logic [15:0] r_ac;
  logic [15:0] r_ir;
  logic [15:0] r_mbr;
  logic        r_halted;
  logic        r_illegal;

  logic [3:0]  w_op;
  logic        w_skip;

  assign w_op = r_ir[15:12];

  // SKIPCOND condition: ir[11:10] selects AC<0, AC==0, AC>0 or never.
  always_comb begin
    w_skip = 1'b0;
    case (r_ir[11:10])
      2'b00:   w_skip = r_ac[15];
      2'b01:   w_skip = (r_ac == 16'h0000);
      2'b10:   w_skip = !r_ac[15] && (r_ac != 16'h0000);
      default: w_skip = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_ac      <= 16'h0000;
      r_ir      <= 16'h0000;
      r_mbr     <= 16'h0000;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      case (r_state)
        S_IDLE:    if (i_start) r_state <= S_FETCH_A;
        S_FETCH_A: r_state <= S_FETCH_D;
        S_FETCH_D: begin
          r_ir    <= i_mem_rdata;
          r_pc    <= r_pc + 12'd1;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_state <= S_FETCH_A;
          case (w_op)
            4'h0: ;
            4'h1, 4'h3, 4'h4, 4'h5, 4'h6: r_state <= S_OPER_A;
            4'h2: r_state <= S_STORE;
            4'h7: begin
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end
            // pc already points past SKIPCOND, so a skip is one more increment
            4'h8: if (w_skip) r_pc <= r_pc + 12'd1;
            4'h9: r_pc <= r_ir[11:0];
            4'hA: r_ac <= 16'h0000;
            default: r_illegal <= 1'b1;
          endcase
        end
        S_OPER_A:  r_state <= S_OPER_D;
        S_OPER_D: begin
          r_mbr   <= i_mem_rdata;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_ac    <= (w_op == 4'h1) ? r_mbr : i_alu_result;
          r_state <= S_FETCH_A;
        end
        S_STORE:   r_state <= S_FETCH_A;
        S_HALT:    r_state <= S_HALT;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  // Operand phases and STORE address the operand; every other state shows pc.
  always_comb begin
    o_mem_addr = {4'b0000, r_pc};
    if (r_state == S_OPER_A || r_state == S_STORE)
      o_mem_addr = {4'b0000, r_ir[11:0]};
  end

  always_comb begin
    o_alu_opcode = 4'b0000;
    if (r_state == S_EXEC) begin
      case (w_op)
        4'h4:    o_alu_opcode = 4'b0001;
        4'h5:    o_alu_opcode = 4'b1000;
        4'h6:    o_alu_opcode = 4'b1001;
        default: o_alu_opcode = 4'b0000;
      endcase
    end
  end

  assign o_mem_we     = (r_state == S_STORE);
  assign o_mem_wdata  = r_ac;
  assign o_alu_a      = r_ac;
  assign o_alu_b      = r_mbr;
  assign o_pc         = r_pc;
  assign o_ac         = r_ac;
  assign o_ir         = r_ir;
  assign o_halted     = r_halted;
  assign o_illegal_op = r_illegal;

endmodule

// File: tb/tb_fetch_execute_sequencer.sv
// Testbench for fetch_execute_sequencer. An instruction-level interpreter
// runs each program on its own copy of memory. It queues timed expectations:
// architectural state at every instruction boundary, store cycles, and ALU
// selects during EXEC. A negedge monitor pops these expectations and compares
// them against the DUT.
module tb_fetch_execute_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, alu_a, alu_b, alu_result, ac, ir;
  logic        mem_we, halted, illegal_op;
  logic [3:0]  alu_opcode;
  logic [11:0] pc;

  fetch_execute_sequencer #(.RESET_PC(12'h000)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
    .i_mem_rdata(mem_rdata),
    .o_alu_opcode(alu_opcode), .o_alu_a(alu_a), .o_alu_b(alu_b),
    .i_alu_result(alu_result),
    .o_pc(pc), .o_ac(ac), .o_ir(ir), .o_halted(halted), .o_illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // main memory: synchronous read, write on STORE
  logic [15:0] dmem [4096];
  always @(posedge clk) begin
    if (mem_we) dmem[mem_addr[11:0]] <= mem_wdata;
    mem_rdata <= dmem[mem_addr[11:0]];
  end

  always_comb begin
    case (alu_opcode)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b1000: alu_result = alu_a & alu_b;
      4'b1001: alu_result = alu_a | alu_b;
      default: alu_result = 16'h0000;
    endcase
  end

  typedef struct {
    int          t;
    int          kind;   // 0 boundary, 1 alu select, 2 store
    logic [11:0] pc;     // pc at boundary / store address
    logic [15:0] ac;
    logic [15:0] ir;
    logic [15:0] v;      // alu select or store data
    bit          ill;
    bit          hlt;
  } ev_t;

  ev_t         evq[$];
  logic [15:0] mm [4096];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  bit          run_en = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void push_ev(int t, int kind, logic [11:0] p, logic [15:0] a,
                                  logic [15:0] i, logic [15:0] v, bit ill, bit hlt);
    ev_t e;
    e.t = t; e.kind = kind; e.pc = p; e.ac = a; e.ir = i; e.v = v; e.ill = ill; e.hlt = hlt;
    evq.push_back(e);
  endfunction

  // monitor: cycle 0 is the first FETCH_A
  always @(negedge clk) begin
    if (!run_en) cyc = 0;
    else begin
      bit we_exp;
      bit ill_exp;
      we_exp = 1'b0;
      ill_exp = 1'b0;
      while (evq.size() > 0 && evq[0].t == cyc) begin
        ev_t e;
        e = evq.pop_front();
        case (e.kind)
          0: begin
            chk("fetch_addr", 32'(mem_addr), 32'({4'b0000, e.pc}));
            chk("pc", 32'(pc), 32'(e.pc));
            chk("ac", 32'(ac), 32'(e.ac));
            chk("ir", 32'(ir), 32'(e.ir));
            chk("halted", 32'(halted), 32'(e.hlt));
            chk("alu_idle", 32'(alu_opcode), 32'd0);
            ill_exp = e.ill;
          end
          1: chk("alu_opcode_exec", 32'(alu_opcode), 32'(e.v[3:0]));
          default: begin
            we_exp = 1'b1;
            chk("store_addr", 32'(mem_addr), 32'({4'b0000, e.pc}));
            chk("store_data", 32'(mem_wdata), 32'(e.v));
          end
        endcase
      end
      chk("mem_we", 32'(mem_we), 32'(we_exp));
      chk("illegal_op", 32'(illegal_op), 32'(ill_exp));
      cyc++;
    end
  end

  task automatic setw(input logic [11:0] a, input logic [15:0] v);
    dmem[a] = v;
    mm[a] = v;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) setw(12'(i), 16'h0000);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Interpret the program in mm at instruction level, queue expectations,
  // then run the DUT for the same number of cycles.
  task automatic run(input int max_ins);
    logic [11:0] p, f;
    logic [15:0] a, iv, w;
    bit          ill, hlt, skip;
    int          t, len, diffs;
    p = 12'h000; a = 16'h0000; iv = 16'h0000; ill = 1'b0; hlt = 1'b0; t = 0;
    do_reset();
    for (int k = 0; k < max_ins && !hlt; k++) begin
      push_ev(t, 0, p, a, iv, 16'h0, ill, 1'b0);
      w = mm[p]; iv = w; p = p + 12'd1; f = w[11:0]; ill = 1'b0; len = 3;
      case (w[15:12])
        4'h0: ;
        4'h1: begin a = mm[f]; len = 6; end
        4'h2: begin push_ev(t + 3, 2, f, 16'h0, 16'h0, a, 1'b0, 1'b0); mm[f] = a; len = 4; end
        4'h3: begin a = a + mm[f]; len = 6; push_ev(t + 5, 1, 12'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0); end
        4'h4: begin a = a - mm[f]; len = 6; push_ev(t + 5, 1, 12'h0, 16'h0, 16'h0, 16'h1, 1'b0, 1'b0); end
        4'h5: begin a = a & mm[f]; len = 6; push_ev(t + 5, 1, 12'h0, 16'h0, 16'h0, 16'h8, 1'b0, 1'b0); end
        4'h6: begin a = a | mm[f]; len = 6; push_ev(t + 5, 1, 12'h0, 16'h0, 16'h0, 16'h9, 1'b0, 1'b0); end
        4'h7: hlt = 1'b1;
        4'h8: begin
          case (w[11:10])
            2'd0:    skip = $signed(a) < 0;
            2'd1:    skip = (a == 16'h0000);
            2'd2:    skip = $signed(a) > 0;
            default: skip = 1'b0;
          endcase
          if (skip) p = p + 12'd1;
        end
        4'h9: p = f;
        4'hA: a = 16'h0000;
        default: ill = 1'b1;
      endcase
      t += len;
    end
    push_ev(t, 0, p, a, iv, 16'h0, ill, hlt);

    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0; run_en = 1'b1;
    repeat (t + 1) @(posedge clk);
    #1;
    if (hlt) begin
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("halt_hold_halted", 32'(halted), 32'd1);
      chk("halt_hold_pc", 32'(pc), 32'(p));
    end
    run_en = 1'b0;
    chk("scoreboard_drained", 32'(evq.size()), 32'd0);
    evq.delete();
    diffs = 0;
    for (int i = 0; i < 4096; i++) if (dmem[i] !== mm[i]) diffs++;
    chk("mem_image", 32'(diffs), 32'd0);
  endtask

  task automatic rand_fill();
    for (int i = 0; i < 4096; i++) begin
      int r, s;
      logic [3:0] op;
      r = $urandom_range(0, 99);
      if (r < 3) op = 4'h7;
      else if (r < 10) op = 4'($urandom_range(11, 15));
      else begin
        s = $urandom_range(0, 9);
        op = (s < 7) ? 4'(s) : 4'(s + 1);
      end
      setw(12'(i), {op, 12'($urandom)});
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    clear_mem();
    @(negedge clk);
    chk("rst_pc", 32'(pc), 32'h000);
    chk("rst_ac", 32'(ac), 32'h0);
    chk("rst_ir", 32'(ir), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_illegal", 32'(illegal_op), 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_alu", 32'(alu_opcode), 32'h0);

    // LOAD / ADD wrap / SUBT
    clear_mem();
    setw(12'h000, 16'h1005); setw(12'h001, 16'h3006); setw(12'h002, 16'h4007);
    setw(12'h003, 16'h7000); setw(12'h005, 16'h0042); setw(12'h006, 16'hFFC0);
    setw(12'h007, 16'h0003);
    run(10);
    chk("arith_final_ac", 32'(ac), 32'hFFFF);

    // STORE then reload
    clear_mem();
    setw(12'h000, 16'h1010); setw(12'h001, 16'h2007); setw(12'h002, 16'hA000);
    setw(12'h003, 16'h1007); setw(12'h004, 16'h7000); setw(12'h010, 16'hBEEF);
    run(10);
    chk("store_mem7", 32'(dmem[12'h007]), 32'hBEEF);
    chk("store_reload_ac", 32'(ac), 32'hBEEF);

    // SKIPCOND AC==0 at 0x010, then loops with AC=1 (no skip)
    clear_mem();
    setw(12'h000, 16'h9010); setw(12'h010, 16'h8400); setw(12'h011, 16'h0000);
    setw(12'h012, 16'h1020); setw(12'h013, 16'h9010); setw(12'h020, 16'h0001);
    run(12);

    // SKIPCOND AC<0 with AC=0x8000 skips the illegal word
    clear_mem();
    setw(12'h000, 16'h1005); setw(12'h001, 16'h8000); setw(12'h002, 16'hF000);
    setw(12'h003, 16'h7000); setw(12'h005, 16'h8000);
    run(10);
    chk("skip_neg_pc", 32'(pc), 32'h004);

    // JUMP to 0xFFF and fetch wrap to 0x000
    clear_mem();
    setw(12'h000, 16'h9FFF);
    run(5);

    // SKIPCOND skip from pc=0xFFF wraps to 0x000
    clear_mem();
    setw(12'h000, 16'h9FFE); setw(12'hFFE, 16'h8400); setw(12'hFFF, 16'hF000);
    run(3);

    // illegal opcodes continue, then HALT ignores start
    clear_mem();
    setw(12'h000, 16'hF000); setw(12'h001, 16'hB123); setw(12'h002, 16'h7000);
    run(10);
    chk("halt_ir", 32'(ir), 32'h7000);

    // reset during STORE: no write, reset values at once
    clear_mem();
    setw(12'h000, 16'h1005); setw(12'h001, 16'h2020); setw(12'h002, 16'h7000);
    setw(12'h005, 16'hBEEF); setw(12'h020, 16'h1234);
    do_reset();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (!mem_we && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("midstore_we_seen", 32'(mem_we), 32'd1);
    chk("midstore_addr", 32'(mem_addr), 32'h0020);
    rst = 1'b1;
    #1;
    chk("midstore_rst_we", 32'(mem_we), 32'd0);
    chk("midstore_rst_pc", 32'(pc), 32'h000);
    chk("midstore_rst_ac", 32'(ac), 32'h0);
    chk("midstore_rst_ir", 32'(ir), 32'h0);
    @(posedge clk); @(negedge clk);
    chk("midstore_no_write", 32'(dmem[12'h020]), 32'h1234);
    rst = 1'b0;

    // random programs
    for (int r = 0; r < 12; r++) begin
      rand_fill();
      run(40);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
